// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave transmit path.
package spi_pkg;
  localparam int P_DWIDTH = 8;
  localparam logic [P_DWIDTH-1:0] P_DUMMY_DEFAULT = 8'hFF;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} tx_state_t;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
endpackage

// File: rtl/spi_tx_shifter_if.sv
// TX buffer read port: first-word-fall-through head data plus a pop strobe.
interface spi_tx_shifter_if;
  import spi_pkg::*;

  logic                ren;
  logic [P_DWIDTH-1:0] rdata;
  logic                rempty;

  modport master (output ren, input rdata, input rempty);
  modport slave  (input ren, output rdata, output rempty);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic P_RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta   <= P_RST_VAL;
      r_sync   <= P_RST_VAL;
      r_sync_d <= P_RST_VAL;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_sync_d;
  assign o_fall  = ~r_sync & r_sync_d;
endmodule

// File: rtl/spi_tx_shifter.sv
// SPI slave transmit shifter: pops bytes from the TX buffer and serialises
// them onto MISO, following oversampled SCK/CS_N in the pclk domain.
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter logic [P_DWIDTH-1:0] P_DUMMY = P_DUMMY_DEFAULT
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic             cfg_lsbf,
  spi_tx_shifter_if.master buf_rd,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             tx_underrun,
  output logic             tx_byte_done,
  output logic             busy
);
  // Index 0 is SCK (idles low out of reset), index 1 is CS_N (idles high).
  localparam logic [1:0] LP_SYNC_RST = 2'b10;

  logic [1:0] w_raw, w_lvl, w_rise, w_fall;

  assign w_raw = {spi_cs_n, spi_sck};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      spi_sync_edge #(.P_RST_VAL(LP_SYNC_RST[gi])) u_sync (
        .clk     (pclk),
        .rst_n   (presetn),
        .i_async (w_raw[gi]),
        .o_level (w_lvl[gi]),
        .o_rise  (w_rise[gi]),
        .o_fall  (w_fall[gi])
      );
    end
  endgenerate

  tx_state_t           r_state, w_state_next;
  logic [P_DWIDTH-1:0] r_shreg, w_shreg_next;
  bit_cnt_t            r_bit_cnt, w_bit_cnt_next;
  logic                r_pending, w_pending_next;
  logic                r_armed, w_armed_next;
  logic                r_cpol, w_cpol_next;
  logic                r_cpha, w_cpha_next;
  logic                w_ren, w_underrun, w_byte_done;
  logic                w_sck_edge, w_lead, w_trail, w_sample, w_launch;
  logic                w_cs_rise, w_cs_fall;

  // A lead edge is one that moves SCK away from its idle (cpol) level.
  assign w_sck_edge = w_rise[0] | w_fall[0];
  assign w_lead     = w_sck_edge & (w_lvl[0] ^ r_cpol);
  assign w_trail    = w_sck_edge & ~(w_lvl[0] ^ r_cpol);
  assign w_sample   = r_cpha ? w_trail : w_lead;
  assign w_launch   = r_cpha ? w_lead : w_trail;
  assign w_cs_rise  = w_rise[1];
  assign w_cs_fall  = w_fall[1];

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_shreg   <= P_DUMMY;
      r_bit_cnt <= '0;
      r_pending <= 1'b0;
      r_armed   <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_pending <= w_pending_next;
      r_armed   <= w_armed_next;
      r_cpol    <= w_cpol_next;
      r_cpha    <= w_cpha_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_pending_next = r_pending;
    w_armed_next   = r_armed;
    w_cpol_next    = r_cpol;
    w_cpha_next    = r_cpha;
    w_ren          = 1'b0;
    w_underrun     = 1'b0;
    w_byte_done    = 1'b0;
    // CS release wins over everything, including a pending LOAD pop.
    if (w_cs_rise) begin
      w_state_next   = IDLE;
      w_bit_cnt_next = '0;
      w_pending_next = 1'b0;
      w_armed_next   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            w_armed_next = 1'b1;
            w_cpol_next  = cfg_cpol;
            w_cpha_next  = cfg_cpha;
            if (!cfg_cpha) w_state_next = LOAD;
          end else if (r_armed && w_launch) begin
            w_state_next = LOAD;
          end
        end
        LOAD: begin
          if (!buf_rd.rempty) begin
            w_shreg_next = buf_rd.rdata;
            w_ren        = 1'b1;
          end else begin
            w_shreg_next = P_DUMMY;
            w_underrun   = 1'b1;
          end
          w_state_next = SHIFT;
        end
        SHIFT: begin
          if (w_sample) begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              w_byte_done    = 1'b1;
              w_pending_next = 1'b1;
            end
          end
          if (w_launch) begin
            if (r_pending) begin
              w_state_next   = LOAD;
              w_pending_next = 1'b0;
            end else if (cfg_lsbf) begin
              w_shreg_next = {1'b1, r_shreg[P_DWIDTH-1:1]};
            end else begin
              w_shreg_next = {r_shreg[P_DWIDTH-2:0], 1'b1};
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign buf_rd.ren   = w_ren;
  assign tx_underrun  = w_underrun;
  assign tx_byte_done = w_byte_done;
  assign busy         = (r_state != IDLE);
  assign spi_miso_oe  = ~w_lvl[1];
  assign spi_miso     = (r_state == IDLE) ? 1'b1
                      : (cfg_lsbf ? r_shreg[0] : r_shreg[P_DWIDTH-1]);
endmodule

// File: tb/tb_spi_tx_shifter.sv
// Directed bench for spi_tx_shifter: FIFO model on the read port, SPI master driven by tasks.
module tb_spi_tx_shifter;
  import spi_pkg::*;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsbf = 1'b0;
  logic spi_sck = 1'b0, spi_cs_n = 1'b1;
  logic spi_miso, spi_miso_oe, tx_underrun, tx_byte_done, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int ren_cnt = 0, und_cnt = 0, done_cnt = 0, bad_ren = 0;
  logic [15:0] rx_bits;
  int base_ren, base_und, base_done;

  always #5 pclk = ~pclk;

  spi_tx_shifter_if bif();
  assign bif.rdata  = fifo_mem[rd_ptr[4:0]];
  assign bif.rempty = (rd_ptr == wr_ptr);

  spi_tx_shifter dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .cfg_cpol     (cfg_cpol),
    .cfg_cpha     (cfg_cpha),
    .cfg_lsbf     (cfg_lsbf),
    .buf_rd       (bif),
    .spi_sck      (spi_sck),
    .spi_cs_n     (spi_cs_n),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .tx_underrun  (tx_underrun),
    .tx_byte_done (tx_byte_done),
    .busy         (busy)
  );

  always @(posedge pclk) begin
    if (bif.ren) begin
      rd_ptr  <= rd_ptr + 1;
      ren_cnt <= ren_cnt + 1;
      if (bif.rempty || !busy) bad_ren <= bad_ren + 1;
    end
    if (tx_underrun)  und_cnt  <= und_cnt + 1;
    if (tx_byte_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cs_start(input logic cpol, input logic cpha, input logic lsbf);
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    cfg_lsbf = lsbf;
    spi_sck  = cpol;
    wait_clk(8);
    spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end(input logic cpol);
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
    spi_sck = cpol;
    wait_clk(8);
  endtask

  // Drive nbits SCK cycles; MISO is captured just before each sample edge.
  task automatic xfer(input logic cpol, input logic cpha, input int nbits, input bit skip_last_trail);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        rx_bits = {rx_bits[14:0], spi_miso};
        spi_sck = ~cpol;
        wait_clk(8);
        if (!(skip_last_trail && i == nbits - 1)) spi_sck = cpol;
        wait_clk(8);
      end else begin
        spi_sck = ~cpol;
        wait_clk(8);
        rx_bits = {rx_bits[14:0], spi_miso};
        spi_sck = cpol;
        wait_clk(8);
      end
    end
  endtask

  task automatic snap();
    base_ren  = ren_cnt;
    base_und  = und_cnt;
    base_done = done_cnt;
    rx_bits   = '0;
  endtask

  initial begin
    // Reset state
    wait_clk(4);
    check("rst_oe", spi_miso_oe, 1'b0);
    check("rst_miso", spi_miso, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ren", bif.ren, 1'b0);
    check("rst_underrun", tx_underrun, 1'b0);
    check("rst_byte_done", tx_byte_done, 1'b0);
    presetn = 1'b1;
    wait_clk(8);

    // Mode 0, MSB first, single byte A5
    push(8'hA5);
    snap();
    cs_start(1'b0, 1'b0, 1'b0);
    check("m0_oe", spi_miso_oe, 1'b1);
    xfer(1'b0, 1'b0, 8, 1'b1);
    cs_end(1'b0);
    check("m0_data", rx_bits[7:0], 8'hA5);
    check("m0_ren", ren_cnt - base_ren, 1);
    check("m0_done", done_cnt - base_done, 1);
    check("m0_underrun", und_cnt - base_und, 0);

    // Mode 3, LSB first, two bytes 3C C3
    push(8'h3C);
    push(8'hC3);
    snap();
    cs_start(1'b1, 1'b1, 1'b1);
    xfer(1'b1, 1'b1, 8, 1'b0);
    check("m3_ren_after8", ren_cnt - base_ren, 1);
    xfer(1'b1, 1'b1, 1, 1'b0);
    check("m3_ren_after9", ren_cnt - base_ren, 2);
    xfer(1'b1, 1'b1, 7, 1'b0);
    cs_end(1'b1);
    check("m3_data", rx_bits, 16'h3CC3);
    check("m3_ren_total", ren_cnt - base_ren, 2);
    check("m3_done", done_cnt - base_done, 2);

    // Empty FIFO, mode 0: dummy byte and one underrun
    snap();
    cs_start(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 8, 1'b1);
    cs_end(1'b0);
    check("empty_data", rx_bits[7:0], 8'hFF);
    check("empty_underrun", und_cnt - base_und, 1);
    check("empty_ren", ren_cnt - base_ren, 0);

    // CS released after 3 bits of 81; next session starts fresh on 42
    push(8'h81);
    push(8'h42);
    snap();
    cs_start(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 3, 1'b0);
    check("abort_bits", rx_bits[2:0], 3'b100);
    check("abort_busy_before", busy, 1'b1);
    spi_cs_n = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("abort_busy_3clk", busy, 1'b0);
    wait_clk(16);
    check("abort_ren", ren_cnt - base_ren, 1);
    rx_bits = '0;
    cs_start(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 8, 1'b1);
    cs_end(1'b0);
    check("abort_next_data", rx_bits[7:0], 8'h42);
    check("abort_next_ren", ren_cnt - base_ren, 2);

    // cpha change mid-transfer is ignored until the next CS assertion
    push(8'h96);
    push(8'h69);
    snap();
    cs_start(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 2, 1'b0);
    cfg_cpha = 1'b1;
    xfer(1'b0, 1'b0, 6, 1'b1);
    cs_end(1'b0);
    check("cpha_hold_data", rx_bits[7:0], 8'h96);
    check("cpha_hold_ren", ren_cnt - base_ren, 1);
    rx_bits = '0;
    cs_start(1'b0, 1'b1, 1'b0);
    xfer(1'b0, 1'b1, 8, 1'b0);
    cs_end(1'b0);
    check("mode1_data", rx_bits[7:0], 8'h69);
    check("mode1_ren", ren_cnt - base_ren, 2);

    // Reset asserted mid-byte
    push(8'h5A);
    cs_start(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 3, 1'b0);
    check("midrst_busy_before", busy, 1'b1);
    presetn = 1'b0;
    @(posedge pclk);
    #1;
    check("midrst_oe", spi_miso_oe, 1'b0);
    check("midrst_miso", spi_miso, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ren", bif.ren, 1'b0);
    wait_clk(2);
    spi_cs_n = 1'b1;
    wait_clk(4);
    presetn = 1'b1;
    wait_clk(8);

    check("ren_protocol", bad_ren, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
